// File: rtl/seq_priority_encoder_if.sv
// Handshake bundle for seq_priority_encoder.
// A request word enters on in_*. One index per beat leaves on out_*.
// slave  : the encoder side.
// master : the side that supplies words and consumes indices (for example a testbench).
interface seq_priority_encoder_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_bits;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             busy;

  modport slave (
    input  in_valid,
    input  in_bits,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last,
    output busy
  );

  modport master (
    output in_valid,
    output in_bits,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last,
    input  busy
  );
endinterface

// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder.
// It captures a multi-hot request word and emits the index of every set bit, lowest index first.
// It emits one index per accepted output beat, with valid/ready handshakes on both sides.
// All outputs are registers, so no input reaches an output combinationally.
// Optional feature: define SEQ_PENC_ZERO_ERR_EN to add the err port.
//   err pulses for one cycle after an all-zero word is accepted.
//   Without the macro, zero words are dropped silently.
module seq_priority_encoder #(
  parameter int WIDTH = 8,             // power of 2, >= 2
  parameter int IDX_W = $clog2(WIDTH)  // must equal log2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef SEQ_PENC_ZERO_ERR_EN
  output logic                  err,
`endif
  seq_priority_encoder_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             out_last_q;
  logic             busy_q;
`ifdef SEQ_PENC_ZERO_ERR_EN
  logic             err_q;
`endif

  // Bits still to be emitted once the current beat transfers
  logic [WIDTH-1:0] pend_after_beat;

  // Position of the lowest set bit.
  // The scan runs from the top down, so the last hit wins.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit of v is set
  function automatic logic single_bit(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  // Clear the bit being handed out on the current beat
  always_comb begin
    pend_after_beat = pend & ~(WIDTH'(1) << out_idx_q);
  end

  // Control FSM with registered outputs.
  // out_idx and out_last are precomputed from the next value of pend.
  // They are therefore valid in the same cycle that out_valid rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pend        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SEQ_PENC_ZERO_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
`ifdef SEQ_PENC_ZERO_ERR_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.in_bits != '0) begin
              state       <= EMIT;
              pend        <= bus.in_bits;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b1;
              out_idx_q   <= lowest_idx(bus.in_bits);
              out_last_q  <= single_bit(bus.in_bits);
            end else begin
              // An all-zero word is consumed without producing a beat
`ifdef SEQ_PENC_ZERO_ERR_EN
              err_q <= 1'b1;
`endif
            end
          end
        end
        EMIT: begin
          // in_valid is ignored here; in_ready is low, so no word is taken
          if (bus.out_ready) begin
            pend <= pend_after_beat;
            if (out_last_q) begin
              state       <= IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              out_idx_q   <= '0;
              out_last_q  <= 1'b0;
            end else begin
              out_idx_q   <= lowest_idx(pend_after_beat);
              out_last_q  <= single_bit(pend_after_beat);
            end
          end
        end
        default: begin
          state       <= IDLE;
          pend        <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_idx_q   <= '0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
`ifdef SEQ_PENC_ZERO_ERR_EN
  assign err = err_q;
`endif

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed testbench for seq_priority_encoder.
// Inputs change 1 ns after a rising edge.
// Outputs are sampled at that same point, so they show the registers updated by that edge.
module tb_seq_priority_encoder;

  logic clk;
  logic reset;
`ifdef SEQ_PENC_ZERO_ERR_EN
  logic err;
`endif
  int   checks;
  int   errors;

  seq_priority_encoder_if #(.WIDTH(8), .IDX_W(3)) bus ();

  seq_priority_encoder #(.WIDTH(8), .IDX_W(3)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef SEQ_PENC_ZERO_ERR_EN
    .err   (err),
`endif
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word for a single cycle; the encoder is expected to be in IDLE
  task automatic send(input logic [7:0] w);
    check("send_in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_bits  = w;
    step();
    bus.in_valid = 1'b0;
    bus.in_bits  = '0;
  endtask

  task automatic beat(input string tag, input int idx, input int last);
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_idx"},   32'(bus.out_idx),   32'(idx));
    check({tag, "_last"},  32'(bus.out_last),  32'(last));
    check({tag, "_rdy"},   32'(bus.in_ready),  0);
    check({tag, "_busy"},  32'(bus.busy),      1);
  endtask

  task automatic idle(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_rdy"},   32'(bus.in_ready),  1);
    check({tag, "_busy"},  32'(bus.busy),      0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bits   = '0;
    bus.out_ready = 1'b0;
    step();
    step();

    // Reset values
    idle("rst");
    check("rst_idx",  32'(bus.out_idx),  0);
    check("rst_last", 32'(bus.out_last), 0);
`ifdef SEQ_PENC_ZERO_ERR_EN
    check("rst_err", 32'(err), 0);
`endif
    reset = 1'b0;
    step();
    idle("post_rst");

    // Single bit 0x04: index 2 as the only beat
    bus.out_ready = 1'b1;
    send(8'h04);
    beat("w04", 2, 1);
    step();
    idle("w04_done");

    // 0x81: index 0, then index 7 marked last
    send(8'h81);
    beat("w81_b0", 0, 0);
    step();
    beat("w81_b1", 7, 1);
    step();
    idle("w81_done");

    // 0xFF: eight back-to-back beats
    send(8'hFF);
    for (int i = 0; i < 8; i++) begin
      beat($sformatf("wff_b%0d", i), i, (i == 7) ? 1 : 0);
      step();
    end
    idle("wff_done");

    // 0x12 under backpressure: index 1 held for three cycles
    bus.out_ready = 1'b0;
    send(8'h12);
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("w12_hold%0d", i), 1, 0);
      step();
    end
    beat("w12_b0", 1, 0);
    bus.out_ready = 1'b1;
    step();
    beat("w12_b1", 4, 1);
    step();
    idle("w12_done");

    // Zero word: consumed, no beat
    send(8'h00);
    idle("w00");
`ifdef SEQ_PENC_ZERO_ERR_EN
    check("w00_err", 32'(err), 1);
`endif
    step();
    idle("w00_after");
`ifdef SEQ_PENC_ZERO_ERR_EN
    check("w00_err_clr", 32'(err), 0);
`endif

    // Top bit alone
    send(8'h80);
    beat("w80", 7, 1);
    step();
    idle("w80_done");

    // A word offered while in EMIT must not be taken
    bus.out_ready = 1'b0;
    send(8'h03);
    beat("w03_b0", 0, 0);
    bus.in_valid = 1'b1;
    bus.in_bits  = 8'h80;
    step();
    beat("w03_ign", 0, 0);
    bus.in_valid  = 1'b0;
    bus.in_bits   = '0;
    bus.out_ready = 1'b1;
    step();
    beat("w03_b1", 1, 1);
    step();
    idle("w03_done");
    step();
    idle("w03_no_extra");

    // Reset after the first beat of 0xF0 discards the rest at once
    send(8'hF0);
    beat("wf0_b0", 4, 0);
    step();
    beat("wf0_b1", 5, 0);
    reset = 1'b1;
    #1;
    idle("wf0_rst");
    check("wf0_rst_idx", 32'(bus.out_idx), 0);
    #2;
    reset = 1'b0;
    step();
    idle("wf0_rel");
    send(8'h02);
    beat("w02", 1, 1);
    step();
    idle("w02_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
